// File: rtl/fpu_ftoi.sv
// Multicycle pinkyfloat (1/8/7) to 16-bit signed integer converter: truncates toward zero, saturates on overflow.
// Define FTOI_BARREL_EN for a single-cycle barrel shift (fixed 2-cycle latency); default is a 1-bit/cycle shifter.
module fpu_ftoi (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] op,
  output logic [15:0] result,
  output logic        done,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [7:0]  exp_in;
  logic [15:0] m_in;
  logic        cls_zero, cls_sat, cls_normal, cls_left, cls_ovf;
  logic [3:0]  cls_n;

  logic [15:0] mag;
  logic        sign, sat_ovf, sat;
`ifndef FTOI_BARREL_EN
  logic        left;
  logic [3:0]  cnt;
`endif

  assign exp_in = op[14:7];
  assign m_in   = {8'b0, 1'b1, op[6:0]};
  assign busy   = (state != IDLE);

  // Operand classification. Exponent 134 (e=7) is the unshifted point; for the
  // NORMAL range 127..141 the low nibble alone yields |E-134| modulo 16.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cls_zero   = (exp_in < 8'd127);
    cls_sat    = (exp_in >= 8'd142);
    cls_normal = !cls_zero && !cls_sat;
    cls_left   = (exp_in >= 8'd134);
    cls_n      = cls_left ? (exp_in[3:0] - 4'd6) : (4'd6 - exp_in[3:0]);
    // -32768 is representable exactly, so it saturates without flagging overflow.
    cls_ovf    = cls_sat && !(op[15] && exp_in == 8'd142 && op[6:0] == 7'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef FTOI_BARREL_EN
          state_next = FINISH;
`else
          state_next = (cls_normal && cls_n != 4'd0) ? SHIFT : FINISH;
`endif
        end
      end
`ifndef FTOI_BARREL_EN
      SHIFT:   if (cnt == 4'd1) state_next = FINISH;
`endif
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag     <= '0;
      sign    <= 1'b0;
      sat     <= 1'b0;
      sat_ovf <= 1'b0;
`ifndef FTOI_BARREL_EN
      left    <= 1'b0;
      cnt     <= '0;
`endif
      result  <= '0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign    <= op[15];
            sat     <= cls_sat;
            sat_ovf <= cls_ovf;
`ifdef FTOI_BARREL_EN
            if (cls_zero)      mag <= '0;
            else if (cls_left) mag <= m_in << cls_n;
            else               mag <= m_in >> cls_n;
`else
            left <= cls_left;
            cnt  <= cls_n;
            mag  <= cls_zero ? 16'd0 : m_in;
`endif
          end
        end
`ifndef FTOI_BARREL_EN
        SHIFT: begin
          mag <= left ? (mag << 1) : (mag >> 1);
          cnt <= cnt - 4'd1;
        end
`endif
        FINISH: begin
          if (sat) result <= sign ? 16'h8000 : 16'h7FFF;
          else     result <= sign ? -mag : mag;
          ovf  <= sat_ovf;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_ftoi.sv
// Scoreboard bench for fpu_ftoi: expected result/ovf/done-cycle queued at issue, compared when done pulses.
module tb_fpu_ftoi;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] op;
  logic [15:0] result;
  logic        done, busy, ovf;

`ifdef FTOI_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  typedef struct {
    logic [15:0] op;
    logic [15:0] res;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t item;
  int   cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  fpu_ftoi dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .result (result),
    .done   (done),
    .busy   (busy),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference conversion from the float definition: value = 1.m * 2^(E-127), truncated.
  function automatic void model(input logic [15:0] x, output logic [15:0] r,
                                output logic v, output int lat);
    int ex, e, mg, n;
    ex = int'(x[14:7]);
    n  = 0;
    if (ex < 127) begin
      r = 16'h0000; v = 1'b0;
    end else if (ex >= 142) begin
      if (x[15]) begin
        r = 16'h8000;
        v = !(ex == 142 && x[6:0] == 7'd0);
      end else begin
        r = 16'h7FFF; v = 1'b1;
      end
    end else begin
      e  = ex - 127;
      mg = 128 + int'(x[6:0]);
      if (e >= 7) begin n = e - 7; mg = mg << n; end
      else        begin n = 7 - e; mg = mg >> n; end
      r = x[15] ? 16'(-mg) : 16'(mg);
      v = 1'b0;
    end
    lat = BARREL ? 2 : n + 2;
  endfunction

  // Called at a negedge; drives the request for the next (accepting) edge.
  task automatic issue(input logic [15:0] x);
    exp_t it;
    int   lat;
    it.op = x;
    model(x, it.res, it.ovf, lat);
    it.due = cycle + lat;
    sb.push_back(it);
    start = 1'b1;
    op    = x;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        item = sb.pop_front();
        check($sformatf("result op=%h", item.op), {16'b0, result}, {16'b0, item.res});
        check($sformatf("ovf op=%h", item.op), {31'b0, ovf}, {31'b0, item.ovf});
        check($sformatf("done_cycle op=%h", item.op), cycle, item.due);
        check("busy_at_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  logic [15:0] vec [8] = '{16'h4040, 16'hC2FF, 16'h46FF, 16'h4700,
                           16'hC700, 16'hFF80, 16'h3F7F, 16'h8000};

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_result", {16'b0, result}, 32'd0);
    check("rst_done",   {31'b0, done},   32'd0);
    check("rst_busy",   {31'b0, busy},   32'd0);
    check("rst_ovf",    {31'b0, ovf},    32'd0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      issue(vec[i]);
      drain();
    end

    // Random operands concentrated around the NORMAL exponent window.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] x;
      x = 16'($urandom);
      x[14:7] = 8'(125 + $urandom_range(0, 19));
      @(negedge clk);
      issue(x);
      drain();
    end

    // A start while busy must be ignored and op not re-captured.
    @(negedge clk);
    issue(16'h4040);
    repeat (BARREL ? 1 : 2) @(negedge clk);
    start = 1'b1;
    op    = 16'h4700;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (12) @(negedge clk);

    // Back-to-back: the next start is sampled in the done cycle.
    @(negedge clk);
    issue(16'h4040);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) begin seen = 1'b1; break; end
      end
      check("b2b_done_seen", {31'b0, seen}, 32'd1);
    end
    issue(16'hC2FF);
    drain();

    // Asynchronous reset mid-operation drops the in-flight conversion.
    @(negedge clk);
    issue(16'h4040);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_busy",   {31'b0, busy},   32'd0);
    check("midrst_done",   {31'b0, done},   32'd0);
    check("midrst_ovf",    {31'b0, ovf},    32'd0);
    check("midrst_result", {16'b0, result}, 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_busy", {31'b0, busy}, 32'd0);

    @(negedge clk);
    issue(16'h46FF);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_ftoi.md
# fpu_ftoi

Multicycle float-to-integer converter for the pinkyfloat FPU: the inverse of the ITOF path.
- Takes a 16-bit pinkyfloat operand: sign, 8-bit exponent with bias 127, 7-bit mantissa with implied leading 1.
- Produces a 16-bit two's-complement integer, truncated toward zero and saturated on overflow.
- Sits behind the processor's stage-2 FPU dispatch for `OPFTOI`, using a start/busy/done handshake so the pipeline can stall while it runs.

## Interface
Parameters:
- none; operand and result format is fixed at 16 bits.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled on a rising edge only while `busy`=0.
- `op`  in  16  float operand; `op[15]` sign, `op[14:7]` exponent, `op[6:0]` mantissa. Captured on the accepting edge.
- `result`  out  16  signed integer result; valid while `done`=1, held until the next accepted `start`.
- `done`  out  1  one-cycle pulse; result is valid.
- `busy`  out  1  high from the accepting edge until the edge that raises `done`.
- `ovf`  out  1  saturation flag; qualified by `done`, held with `result`.

## Operation
Definitions: `E = op[14:7]`, `e = E - 127`, `m = {1'b1, op[6:0]}` (8 bits).

Classification, on the accepting edge:
- ZERO: `E < 127`. Covers E=0, ±0, and all |v|<1. Result 0x0000, ovf=0.
- SAT: `E >= 142`, including E=255. Positive gives 0x7FFF; negative gives 0x8000. ovf=1, except the exact case sign=1, E=142, mant=0 (-32768), which gives 0x8000 with ovf=0.
- NORMAL: `127 <= E <= 141`.
  - Load 16-bit magnitude `mag = {8'b0, m}`.
  - Set shift count `n = |e - 7|`, direction left if `e >= 7`, else right.
  - Bits shifted out on the right are discarded (truncation). No left-shift overflow is possible for e ≤ 14.

State machine, `state` 2 bits:
- IDLE: `busy`=0.
  - On `start`, classify.
  - NORMAL with n>0 goes to SHIFT with cnt=n.
  - All other cases go to FINISH, with mag already final.
- SHIFT: shift `mag` one bit per cycle in the chosen direction and decrement cnt. When cnt==1, go to FINISH.
- FINISH: register the result.
  - `result = sat ? (sign ? 0x8000 : 0x7FFF) : (sign ? -mag : mag)`.
  - Set `done`=1 and `ovf`.
  - Go to IDLE.
- `busy = (state != IDLE)`.

Boundary conditions:
- `start` while busy is ignored; `op` is not re-captured.
- `done` is high in the first IDLE cycle. A `start` sampled in that same cycle is accepted, so back-to-back operation has no bubble.
- Negative results are two's complement of the truncated magnitude, so -127.5 becomes 0xFF81.
- Exponent 255 (inf/NaN) is always SAT; no NaN result encoding is produced.

## Timing
- Reset (`reset`=0, asynchronous): state=IDLE, `busy`=0, `done`=0, `ovf`=0, `result`=0x0000, internal mag/cnt/sign cleared.
  - Takes effect immediately, including mid-SHIFT. The in-flight operation is dropped with no `done`.
- Let the accepting edge be edge 1. `done` is high after edge `n+2` (n as above; n=0 for ZERO/SAT).
  - Latency range is 2 to 9 cycles.
  - `busy` is high after edges 1 through n+1.
- `done` lasts exactly one cycle.
- `result` and `ovf` hold their value until the next FINISH or reset.

## Configuration
- `FTOI_BARREL_EN` defined:
  - NORMAL operands are shifted by a full barrel shifter on the accepting edge. SHIFT is never entered.
  - Latency is a fixed 2 cycles for every operand.
  - `cnt` is not instantiated.
- Undefined (default): iterative one-bit-per-cycle shifter as described; variable latency n+2.
- Results and ovf are bit-identical in both builds.

## Test plan
- `op`=0x4040 (3.0) → `result`=0x0003, ovf=0, done after edge 8 (n=6); barrel build after edge 2.
- `op`=0xC2FF (-127.5) → `result`=0xFF81 (truncated -127), ovf=0, done after edge 3.
- `op`=0x46FF (32640.0, e=14) → 0x7F80 after edge 9. `op`=0x4700 → 0x7FFF, ovf=1. `op`=0xC700 → 0x8000, ovf=0. `op`=0xFF80 → 0x8000, ovf=1.
- `op`=0x3F7F (0.996) → 0x0000. `op`=0x8000 (-0) → 0x0000. Both done after edge 2, ovf=0.
- Start 0x4040, pulse `start` again with 0x4700 on edge 3 → ignored, result 0x0003. Start 0xC2FF in the `done` cycle → accepted, 0xFF81 three edges later.
- Start 0x4040, drive `reset`=0 between edges 3 and 4 → busy/done/ovf/result immediately 0. After release, no `done` until a new `start`.
